// File: rtl/nandy_check_pkg.sv
// Shared definitions for the NAND sweep checker: FSM encodings, input codes and
// vector decoding helpers.
package nandy_check_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StApply  = 2'd1;
  localparam logic [1:0] StCheck  = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  localparam logic [1:0] C0 = 2'd0;
  localparam logic [1:0] C1 = 2'd1;
  localparam logic [1:0] CX = 2'd2;

  function automatic int unsigned nv_of(input int unsigned check_x);
    return (check_x != 0) ? 9 : 4;
  endfunction

  // Returns {a_code, b_code} for vector v.
  function automatic logic [3:0] vec_codes(input logic [3:0] v, input logic check_x);
    if (check_x) return {2'(v / 4'd3), 2'(v % 4'd3)};
    return {1'b0, v[1], 1'b0, v[0]};
  endfunction

  function automatic logic code_val(input logic [1:0] c);
    case (c)
      C0:      return 1'b0;
      C1:      return 1'b1;
      CX:      return 1'bx;
      default: return 1'bx;
    endcase
  endfunction

endpackage

// File: rtl/nand_expect.sv
// Four-state reference NAND: a controlling 0 forces 1, two 1s give 0, anything
// else is unknown.
module nand_expect (
  input  logic a_i,
  input  logic b_i,
  output logic q_o
);

  always_comb begin
    if (a_i === 1'b0 || b_i === 1'b0) begin
      q_o = 1'b1;
    end else if (a_i === 1'b1 && b_i === 1'b1) begin
      q_o = 1'b0;
    end else begin
      q_o = 1'bx;
    end
  end

endmodule

// File: rtl/nand_sweep_checker.sv
// Sweeps every channel of a NAND array through the 0/1(/X) input vectors and
// counts outputs that differ from the four-state reference.
module nand_sweep_checker
  import nandy_check_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned CHECK_X  = 1,
  parameter int unsigned ERRW     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERRW-1:0]     err_count,
  output logic [4:0]          fail_chan,
  output logic [3:0]          fail_vec,
  output logic [CHANNELS-1:0] dut_a,
  output logic [CHANNELS-1:0] dut_b,
  input  logic [CHANNELS-1:0] dut_q
);

  localparam int unsigned NV = nv_of(CHECK_X);
  localparam logic [ERRW-1:0] ErrMax = '1;

  logic [1:0]      state_q, state_d;
  logic [3:0]      v_q, v_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [4:0]      fail_chan_q, fail_chan_d;
  logic [3:0]      fail_vec_q, fail_vec_d;

  logic [3:0]          codes;
  logic                a_bit, b_bit;
  logic [CHANNELS-1:0] expect_val;
  logic [CHANNELS-1:0] mism;
  logic [5:0]          n_mism;
  logic [4:0]          first_chan;
  logic                found;
  logic [ERRW+5:0]     err_sum;
  logic [ERRW-1:0]     err_sat;

  // Stimulus is combinational from state so reset clears it without a clock.
  always_comb begin
    codes = vec_codes(v_q, CHECK_X != 0);
    a_bit = code_val(codes[3:2]);
    b_bit = code_val(codes[1:0]);
    if (state_q == StApply || state_q == StCheck) begin
      dut_a = {CHANNELS{a_bit}};
      dut_b = {CHANNELS{b_bit}};
    end else begin
      dut_a = '0;
      dut_b = '0;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    nand_expect u_expect (
      .a_i (dut_a[gi]),
      .b_i (dut_b[gi]),
      .q_o (expect_val[gi])
    );
  end

  always_comb begin
    mism       = '0;
    n_mism     = '0;
    first_chan = '0;
    found      = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      mism[i] = (dut_q[i] !== expect_val[i]);
      n_mism  = n_mism + {5'd0, mism[i]};
      if (mism[i] && !found) begin
        first_chan = 5'(i);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    err_sum = {6'd0, err_q} + {{ERRW{1'b0}}, n_mism};
    err_sat = (err_sum[ERRW+5:ERRW] != '0) ? ErrMax : err_sum[ERRW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_chan_d = fail_chan_q;
    fail_vec_d  = fail_vec_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StApply;
          v_d         = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          fail_chan_d = '0;
          fail_vec_d  = '0;
        end
      end
      StApply: begin
        if (cnt_q == 8'(SETTLE - 1)) begin
          state_d = StCheck;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCheck: begin
        err_d = err_sat;
        // A zero count means no mismatch has been seen yet in this run.
        if (found && err_q == '0) begin
          fail_chan_d = first_chan;
          fail_vec_d  = v_q;
        end
        if (v_q == 4'(NV - 1)) begin
          state_d = StFinish;
        end else begin
          v_d     = v_q + 4'd1;
          state_d = StApply;
        end
      end
      StFinish: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      v_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_chan_q <= '0;
      fail_vec_q  <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_chan_q <= fail_chan_d;
      fail_vec_q  <= fail_vec_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_chan = fail_chan_q;
  assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Scoreboard bench: three checker instances (X sweep, 0/1 sweep, 32-channel) fed
// by modelled gate arrays; expected run results are queued at start, compared at done.
module tb_nand_sweep_checker;

  typedef struct {
    int errs;
    int chan;
    int vec;
    int pass;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v = 1'b0;
  logic stuck2 = 1'b0;
  int   sel = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   x_seen_nx = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_x, start_nx, start_w;
  logic       busy_x, done_x, pass_x, busy_nx, done_nx, pass_nx, busy_w, done_w, pass_w;
  logic [7:0] err_x, err_nx, err_w;
  logic [4:0] fc_x, fc_nx, fc_w;
  logic [3:0] fv_x, fv_nx, fv_w;
  logic [3:0] a_x, b_x, q_x, a_nx, b_nx, q_nx;
  logic [31:0] a_w, b_w;
  logic [31:0] q_w = '0;

  assign start_x  = (sel == 0) ? start_v : 1'b0;
  assign start_nx = (sel == 1) ? start_v : 1'b0;
  assign start_w  = (sel == 2) ? start_v : 1'b0;

  // Gates under test: plain NAND, with channel 2 of the first array optionally stuck at 1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q_x[i]  = (stuck2 && i == 2) ? 1'b1 : ~(a_x[i] & b_x[i]);
      q_nx[i] = ~(a_nx[i] & b_nx[i]);
    end
  end

  nand_sweep_checker #(.CHANNELS(4), .SETTLE(4), .CHECK_X(1), .ERRW(8)) u_x (
    .clk(clk), .rst_n(rst_n), .start(start_x), .busy(busy_x), .done(done_x), .pass(pass_x),
    .err_count(err_x), .fail_chan(fc_x), .fail_vec(fv_x), .dut_a(a_x), .dut_b(b_x), .dut_q(q_x)
  );

  nand_sweep_checker #(.CHANNELS(4), .SETTLE(4), .CHECK_X(0), .ERRW(8)) u_nx (
    .clk(clk), .rst_n(rst_n), .start(start_nx), .busy(busy_nx), .done(done_nx),
    .pass(pass_nx), .err_count(err_nx), .fail_chan(fc_nx), .fail_vec(fv_nx),
    .dut_a(a_nx), .dut_b(b_nx), .dut_q(q_nx)
  );

  nand_sweep_checker #(.CHANNELS(32), .SETTLE(2), .CHECK_X(1), .ERRW(8)) u_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .busy(busy_w), .done(done_w), .pass(pass_w),
    .err_count(err_w), .fail_chan(fc_w), .fail_vec(fv_w), .dut_a(a_w), .dut_b(b_w), .dut_q(q_w)
  );

  logic s_busy, s_done, s_pass;
  int   s_err, s_fc, s_fv, s_a, s_b;
  always_comb begin
    case (sel)
      1: begin
        s_busy = busy_nx; s_done = done_nx; s_pass = pass_nx; s_err = int'(err_nx);
        s_fc = int'(fc_nx); s_fv = int'(fv_nx); s_a = int'(a_nx); s_b = int'(b_nx);
      end
      2: begin
        s_busy = busy_w; s_done = done_w; s_pass = pass_w; s_err = int'(err_w);
        s_fc = int'(fc_w); s_fv = int'(fv_w); s_a = int'(a_w); s_b = int'(b_w);
      end
      default: begin
        s_busy = busy_x; s_done = done_x; s_pass = pass_x; s_err = int'(err_x);
        s_fc = int'(fc_x); s_fv = int'(fv_x); s_a = int'(a_x); s_b = int'(b_x);
      end
    endcase
  end

  always @(negedge clk) begin
    if (busy_nx && ($isunknown(a_nx) || $isunknown(b_nx))) x_seen_nx <= 1'b1;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Independent run model: every channel sees the same vector; the gate is
  // ideal unless stuck, and each !== against the ideal NAND is one mismatch.
  function automatic exp_t model(input int ch, input int cx, input int settle,
                                 input int stuck_ch, input bit stuck_all, input logic sv);
    exp_t e;
    logic tv[3];
    logic a, b, ideal, q;
    logic [3:0] vb;
    int nv, raw;
    tv[0] = 1'b0; tv[1] = 1'b1; tv[2] = 1'bx;
    nv = (cx != 0) ? 9 : 4;
    raw = 0;
    e.chan = 0;
    e.vec = 0;
    for (int v = 0; v < nv; v++) begin
      vb = 4'(v);
      if (cx != 0) begin
        a = tv[v / 3];
        b = tv[v % 3];
      end else begin
        a = vb[1];
        b = vb[0];
      end
      ideal = ~(a & b);
      for (int c = 0; c < ch; c++) begin
        q = (stuck_all || c == stuck_ch) ? sv : ideal;
        if (q !== ideal) begin
          if (raw == 0) begin
            e.chan = c;
            e.vec = v;
          end
          raw++;
        end
      end
    end
    e.errs = (raw > 255) ? 255 : raw;
    e.pass = (raw == 0) ? 1 : 0;
    e.lat = nv * (settle + 1) + 1;
    return e;
  endfunction

  task automatic run(input string tag, input int s, input exp_t e, input int repulse);
    int t0, lat;
    bit got;
    exp_t x;
    sel = s;
    sb.push_back(e);
    @(negedge clk);
    start_v = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (k == 0) check_eq({tag, "_busy"}, int'(s_busy), 1);
      start_v = (repulse != 0 && cyc - t0 == 9) ? 1'b1 : 1'b0;
      if (s_done) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    start_v = 1'b0;
    x = sb.pop_front();
    if (!got) begin
      check_eq({tag, "_timeout"}, 0, 1);
    end else begin
      check_eq({tag, "_lat"}, lat, x.lat);
      check_eq({tag, "_err"}, s_err, x.errs);
      check_eq({tag, "_chan"}, s_fc, x.chan);
      check_eq({tag, "_vec"}, s_fv, x.vec);
      check_eq({tag, "_pass"}, int'(s_pass), x.pass);
      check_eq({tag, "_idle_busy"}, int'(s_busy), 0);
      check_eq({tag, "_idle_ab"}, s_a | s_b, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    sel = 0;
    #1;
    check_eq("rst_busy", int'(s_busy), 0);
    check_eq("rst_done", int'(s_done), 0);
    check_eq("rst_pass", int'(s_pass), 0);
    check_eq("rst_err", s_err, 0);
    check_eq("rst_ab", s_a | s_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run("ideal_x", 0, model(4, 1, 4, -1, 1'b0, 1'b0), 0);
    stuck2 = 1'b1;
    run("stuck2", 0, model(4, 1, 4, 2, 1'b0, 1'b1), 0);
    stuck2 = 1'b0;
    run("ideal_nx", 1, model(4, 0, 4, -1, 1'b0, 1'b0), 0);
    check_eq("nx_no_x", int'(x_seen_nx), 0);
    run("wide_sat", 2, model(32, 1, 2, -1, 1'b1, 1'b0), 0);
    run("repulse", 0, model(4, 1, 4, -1, 1'b0, 1'b0), 1);

    // Abort a faulty run during vector 5, then rerun cleanly.
    sel = 0;
    stuck2 = 1'b1;
    @(negedge clk);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    repeat (26) @(negedge clk);
    check_eq("pre_rst_busy", int'(s_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", int'(s_busy), 0);
    check_eq("mid_rst_done", int'(s_done), 0);
    check_eq("mid_rst_pass", int'(s_pass), 0);
    check_eq("mid_rst_err", s_err, 0);
    check_eq("mid_rst_chan", s_fc, 0);
    check_eq("mid_rst_vec", s_fv, 0);
    check_eq("mid_rst_ab", s_a | s_b, 0);
    stuck2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_done", int'(s_done), 0);
    run("after_rst", 0, model(4, 1, 4, -1, 1'b0, 1'b0), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
